// File: rtl/timer.sv
// Bus-mapped 32-bit periodic/one-shot timer with auto-reload, overflow flag and
// level interrupt. Four word registers selected by A[1:0]. Reads are registered.
module timer #(
    parameter logic [31:0] CTRL_RST = 32'h0000_0001
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [31:0] A,
    input  logic        CS,
    input  logic        WR,
    input  logic [31:0] I,
    output logic [31:0] O,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        ADDR_CTRL = 2'd0,
        ADDR_AR   = 2'd1,
        ADDR_CNTR = 2'd2,
        ADDR_STAT = 2'd3
    } addr_e;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;
    localparam int CTRL_OS = 2;

    logic [2:0]  r_ctrl;
    logic [31:0] r_ar;
    logic [31:0] r_cntr;
    logic        r_ovf;
    logic [31:0] r_o;
    logic        r_irq;

    addr_e       w_addr;
    logic        w_wr_ctrl;
    logic        w_wr_ar;
    logic        w_wr_cntr;
    logic        w_wr_stat;
    logic        w_rd;
    logic        w_match;
    logic [2:0]  w_ctrl_nxt;
    logic [31:0] w_ar_nxt;
    logic [31:0] w_cntr_nxt;
    logic        w_ovf_nxt;
    logic [31:0] w_rdata;

    // The external decoder already qualifies the upper address bits via CS.
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, A[31:2]};

    assign w_addr    = addr_e'(A[1:0]);
    assign w_wr_ctrl = CS && WR && (w_addr == ADDR_CTRL);
    assign w_wr_ar   = CS && WR && (w_addr == ADDR_AR);
    assign w_wr_cntr = CS && WR && (w_addr == ADDR_CNTR);
    assign w_wr_stat = CS && WR && (w_addr == ADDR_STAT);
    assign w_rd      = CS && !WR;

    // A CNTR write pre-empts the match entirely: no reload, no flag, no one-shot stop.
    assign w_match = r_ctrl[CTRL_EN] && (r_ar != 32'd0) && (r_cntr == r_ar) && !w_wr_cntr;

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_ctrl_nxt = r_ctrl;
        if (w_match && r_ctrl[CTRL_OS]) begin
            w_ctrl_nxt[CTRL_EN] = 1'b0;
        end
        if (w_wr_ctrl) begin
            w_ctrl_nxt = I[2:0];
        end

        w_ar_nxt = w_wr_ar ? I : r_ar;

        w_cntr_nxt = r_cntr;
        if (r_ctrl[CTRL_EN]) begin
            w_cntr_nxt = r_cntr + 32'd1;
        end
        if (w_match || w_wr_ar) begin
            w_cntr_nxt = 32'd0;
        end
        if (w_wr_cntr) begin
            w_cntr_nxt = I;
        end

        // Set beats write-1-to-clear when both land on the same edge.
        w_ovf_nxt = r_ovf;
        if (w_wr_stat && I[1]) begin
            w_ovf_nxt = 1'b0;
        end
        if (w_match) begin
            w_ovf_nxt = 1'b1;
        end

        unique case (w_addr)
            ADDR_CTRL: w_rdata = {29'd0, r_ctrl};
            ADDR_AR:   w_rdata = r_ar;
            ADDR_CNTR: w_rdata = r_cntr;
            ADDR_STAT: w_rdata = {30'd0, r_ovf, r_ctrl[CTRL_EN]};
            default:   w_rdata = 32'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_ctrl <= CTRL_RST[2:0];
            r_ar   <= 32'd0;
            r_cntr <= 32'd0;
            r_ovf  <= 1'b0;
            r_o    <= 32'd0;
            r_irq  <= 1'b0;
        end else begin
            r_ctrl <= w_ctrl_nxt;
            r_ar   <= w_ar_nxt;
            r_cntr <= w_cntr_nxt;
            r_ovf  <= w_ovf_nxt;
            if (w_rd) begin
                r_o <= w_rdata;
            end
            r_irq  <= w_ovf_nxt && w_ctrl_nxt[CTRL_IE];
        end
    end

    assign O   = r_o;
    assign IRQ = r_irq;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: read expectations are queued when a read is
// issued and compared against O once the registered read data appears.
module tb_timer;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b1;
    logic [31:0] A = 32'd0;
    logic        CS = 1'b0;
    logic        WR = 1'b0;
    logic [31:0] I = 32'd0;
    logic [31:0] O;
    logic        IRQ;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q_exp[$];
    string       q_tag[$];

    localparam logic [1:0] R_CTRL = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_CNTR = 2'd2;
    localparam logic [1:0] R_STAT = 2'd3;

    timer #(.CTRL_RST(32'h0000_0001)) dut (
        .CLK   (CLK),
        .RESETn(RESETn),
        .A     (A),
        .CS    (CS),
        .WR    (WR),
        .I     (I),
        .O     (O),
        .IRQ   (IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        CS = 1'b1;
        WR = 1'b1;
        A  = {30'($urandom), addr};
        I  = data;
        @(posedge CLK);
        #1;
        CS = 1'b0;
        WR = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, input string tag, input logic [31:0] exp);
        CS = 1'b1;
        WR = 1'b0;
        A  = {30'($urandom), addr};
        I  = $urandom;
        q_exp.push_back(exp);
        q_tag.push_back(tag);
        @(posedge CLK);
        #1;
        CS = 1'b0;
        check(q_tag.pop_front(), O, q_exp.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and reset values
        #1 RESETn = 1'b0;
        #1;
        check("rst_o", O, 32'd0);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RESETn = 1'b1;
        bus_read(R_CTRL, "rst_ctrl", 32'h1);
        bus_read(R_AR,   "rst_ar",   32'h0);

        // Periodic count with AR=3
        bus_write(R_AR, 32'd3);
        bus_read(R_CNTR, "per_c0",  32'd0);
        bus_read(R_CNTR, "per_c1",  32'd1);
        bus_read(R_CNTR, "per_c2",  32'd2);
        bus_read(R_CNTR, "per_c3",  32'd3);
        bus_read(R_CNTR, "per_wrap", 32'd0);
        bus_read(R_STAT, "per_stat", 32'h3);
        check("per_irq_off", {31'd0, IRQ}, 32'd0);

        // Write-1-to-clear of OVF
        bus_write(R_AR, 32'd100);
        bus_write(R_STAT, 32'h1);
        check("o_hold_wr", O, 32'h3);
        bus_read(R_STAT, "w1c_keep", 32'h3);
        bus_write(R_STAT, 32'h2);
        bus_read(R_STAT, "w1c_clr", 32'h1);

        // One-shot with IRQ
        bus_write(R_AR, 32'd4);
        bus_write(R_CTRL, 32'h7);
        idle(3);
        check("os_irq_pre", {31'd0, IRQ}, 32'd0);
        idle(1);
        check("os_irq", {31'd0, IRQ}, 32'd1);
        bus_read(R_CNTR, "os_cntr",  32'd0);
        bus_read(R_STAT, "os_stat",  32'h2);
        bus_read(R_CTRL, "os_ctrl",  32'h6);
        bus_read(R_CNTR, "os_hold",  32'd0);
        bus_write(R_STAT, 32'h2);
        check("os_irq_clr", {31'd0, IRQ}, 32'd0);

        // Match coincident with OVF clear: set wins
        bus_write(R_CTRL, 32'h1);
        bus_write(R_AR, 32'd5);
        bus_write(R_CNTR, 32'd5);
        bus_write(R_STAT, 32'h2);
        bus_read(R_STAT, "setwin_stat", 32'h3);
        bus_read(R_CNTR, "setwin_cntr", 32'd1);

        // Free-running wrap with AR=0
        bus_write(R_STAT, 32'h2);
        bus_write(R_AR, 32'd0);
        bus_write(R_CNTR, 32'hFFFF_FFFE);
        bus_read(R_CNTR, "wrap_fe", 32'hFFFF_FFFE);
        bus_read(R_CNTR, "wrap_ff", 32'hFFFF_FFFF);
        bus_read(R_CNTR, "wrap_0",  32'd0);
        bus_read(R_CNTR, "wrap_1",  32'd1);
        bus_read(R_STAT, "wrap_stat", 32'h1);

        // Asynchronous reset mid-count
        bus_write(R_CTRL, 32'h3);
        bus_write(R_AR, 32'd2);
        idle(3);
        bus_write(R_AR, 32'd100);
        bus_write(R_CNTR, 32'd7);
        bus_read(R_STAT, "pre_rst_stat", 32'h3);
        check("pre_rst_irq", {31'd0, IRQ}, 32'd1);
        #2 RESETn = 1'b0;
        #1;
        check("async_o",   O, 32'd0);
        check("async_irq", {31'd0, IRQ}, 32'd0);
        #2 RESETn = 1'b1;
        bus_read(R_CNTR, "post_c0",   32'd0);
        bus_read(R_CNTR, "post_c1",   32'd1);
        bus_read(R_CTRL, "post_ctrl", 32'h1);
        bus_read(R_AR,   "post_ar",   32'd0);
        bus_read(R_STAT, "post_stat", 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 Parameter CTRL_RST, default 32'h00000001, CTRL register value after reset (timer running, IRQ off, periodic).
REQ-002 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 RESETn  input  1  reset, asynchronous and active-low.
REQ-004 A  input  32  bus address; only A[1:0] decoded; upper bits ignored (external decoder drives CS).
REQ-005 CS  input  1  chip select; access happens only when 1 at a CLK edge.
REQ-006 WR  input  1  1 = write, 0 = read; qualified by CS.
REQ-007 I  input  32  write data.
REQ-008 O  output  32  registered read data.
REQ-009 IRQ  output  1  interrupt request, registered.

Function
REQ-010 Register map (A[1:0]): 0 CTRL (R/W), 1 AR auto-reload (R/W), 2 CNTR counter (R/W), 3 STAT (R, write-1-to-clear).
REQ-011 CTRL bits: [0] EN count enable; [1] IE IRQ enable; [2] OS one-shot; [31:3] read 0, writes ignored.
REQ-012 STAT bits: [1] OVF overflow flag; [0] EN mirror (read-only); [31:2] read 0.
REQ-013 Read: CS=1, WR=0 at edge N -> O carries the selected register's value as it was before edge N, valid after edge N (1-cycle latency).
REQ-014 O holds its last value on cycles with no read, including write cycles.
REQ-015 Write: CS=1, WR=1 at edge -> register updated at that edge; effect visible from the next cycle.
REQ-016 Counting: EN=1 and AR!=0 -> each edge CNTR increments by 1, except on a match.
REQ-017 Match: CNTR==AR with EN=1 and AR!=0 -> at that edge CNTR<=0 and OVF<=1; period = AR+1 cycles.
REQ-018 AR==0 with EN=1 -> CNTR increments freely and wraps 32'hFFFFFFFF->0; no match, OVF unchanged.
REQ-019 EN=0 -> CNTR holds; no match.
REQ-020 OS=1 -> on a match, EN is also cleared at the same edge (CNTR=0, counting stops).
REQ-021 Write to AR also clears CNTR to 0 at the same edge, restarting the period.
REQ-022 Write to CNTR loads I; this write takes priority over increment and match at that edge.
REQ-023 Write to STAT with I[1]=1 clears OVF; I[1]=0 leaves it; other bits ignored.
REQ-024 Simultaneous match and STAT clear at the same edge -> OVF=1 (set wins).
REQ-025 Simultaneous match and CTRL write -> match takes effect (CNTR=0, OVF=1), then CTRL takes the written value (written EN overrides the OS auto-clear).
REQ-026 IRQ registered: IRQ <= OVF_next & IE_next; asserted in the cycle after OVF becomes 1 (if IE=1), deasserts one cycle after OVF clears or IE is cleared.
REQ-027 Reads of CNTR return the pre-edge value; a read coincident with a match returns AR.

Reset
REQ-028 RESETn=0 asynchronously forces: CTRL=CTRL_RST, AR=0, CNTR=0, OVF=0, O=0, IRQ=0.
REQ-029 On RESETn rising, the first counting edge is the first CLK edge with RESETn=1; a reset mid-count discards CNTR and OVF.

Verification
REQ-030 Reset, write AR=3, no other access -> CNTR reads 0,1,2,3,0,...; OVF=1 from the edge where CNTR 3->0; STAT reads 32'h3.
REQ-031 OVF=1, write STAT I=32'h2 -> STAT reads 32'h1; write I=32'h1 instead -> OVF stays 1.
REQ-032 AR=4, CTRL=32'h7, count through match -> CNTR=0, STAT=32'h2, CTRL reads 32'h6, IRQ=1 one cycle after OVF set; CNTR stays 0.
REQ-033 AR=5, CNTR=5, STAT write I=2 at the match edge -> OVF=1 afterwards (set wins).
REQ-034 AR=0, write CNTR=32'hFFFFFFFE -> CNTR reads ...FFFF then 0, then 1; OVF stays 0.
REQ-035 RESETn pulsed low mid-count between CLK edges (CNTR=7, OVF=1, IRQ=1) -> all outputs/registers take reset values immediately, without waiting for CLK.
